// File: rtl/debug_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_slave_pkg
//  Purpose  : Shared constants and command type for the JTAG debug slave.
//  Revision : 1.0 - initial release
// ============================================================================
package debug_slave_pkg;

    localparam int c_DATA_W = 38;
    localparam int c_IR_W   = 2;

    localparam logic [c_IR_W-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [c_IR_W-1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [c_IR_W-1:0] IR_BREAK     = 2'd2;
    localparam logic [c_IR_W-1:0] IR_TRACECTRL = 2'd3;

    typedef struct packed {
        logic [c_IR_W-1:0]   ir;
        logic [c_DATA_W-1:0] data;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/debug_slave_cmd_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : debug_slave_cmd_sync_if
//  Purpose  : Valid/ready command channel from the debug slave to OCI decoders.
//  Revision : 1.0 - initial release
// ============================================================================
interface debug_slave_cmd_sync_if
    import debug_slave_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int IR_W   = c_IR_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_ir,
        output cmd_data
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_ir,
        input  cmd_data
    );

endinterface
`default_nettype wire

// File: rtl/debug_slave_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : debug_slave_sync_edge
//  Purpose  : Level synchroniser with arm flag and rising-edge strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_slave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic async_in,
    output logic      rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_armed;
    logic                   r_prev;
    logic                   w_sync_out;
    logic                   w_sync_valid;

    assign w_sync_out   = r_sync[SYNC_STAGES-1];
    // The zeros flushed in by reset are not a real observation of the input;
    // r_fill marks when the synchroniser output reflects the pin.
    assign w_sync_valid = r_fill[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= w_sync_out;
            if (w_sync_valid && !w_sync_out) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign rise = r_armed && w_sync_out && !r_prev;

endmodule
`default_nettype wire

// File: rtl/debug_slave_cmd_sync.sv
`default_nettype none
// ============================================================================
//  Module   : debug_slave_cmd_sync
//  Purpose  : Brings JTAG IR/DR updates into clk and queues DR updates as commands.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_slave_cmd_sync
    import debug_slave_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int IR_W        = c_IR_W,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic [IR_W-1:0]          ir_in,
    input  wire logic [DATA_W-1:0]        sr,
    input  wire logic                     vs_uir,
    input  wire logic                     vs_udr,
    debug_slave_cmd_sync_if.master        cmd,
    output logic      [DATA_W-1:0]        jdo,
    output logic                          uir_pulse,
    output logic      [$clog2(DEPTH):0]   level,
    output logic                          overflow,
    input  wire logic                     overflow_clr
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr;
    logic [c_PW-1:0]   r_rd;
    logic [IR_W-1:0]   r_ir_q;
    logic [DATA_W-1:0] r_jdo;
    logic              r_uir_pulse;
    logic              r_overflow;

    logic              w_uir_rise;
    logic              w_udr_rise;
    logic [c_PW-1:0]   w_level;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic [IR_W-1:0]   w_ir_eff;
    entry_t            w_head;

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (w_uir_rise)
    );

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (w_udr_rise)
    );

    assign w_level  = r_wr - r_rd;
    assign w_valid  = (w_level != '0);
    assign w_full   = ((r_wr ^ r_rd) == {1'b1, {c_AW{1'b0}}});
    assign w_pop    = w_valid && cmd.cmd_ready;
    // When full, a same-cycle pop frees the slot the write pointer aliases.
    assign w_wr_en  = w_udr_rise && (!w_full || w_pop);
    assign w_drop   = w_udr_rise && w_full && !w_pop;
    assign w_ir_eff = w_uir_rise ? ir_in : r_ir_q;
    assign w_head   = r_mem[r_rd[c_AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_ir_q      <= '0;
            r_jdo       <= '0;
            r_uir_pulse <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_uir_pulse <= w_uir_rise;
            if (w_uir_rise) begin
                r_ir_q <= ir_in;
            end
            if (w_udr_rise) begin
                r_jdo <= sr;
            end
            if (w_wr_en) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage carries no reset; empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[c_AW-1:0]] <= '{ir: w_ir_eff, data: sr};
        end
    end

    assign cmd.cmd_valid = w_valid;
    assign cmd.cmd_ir    = w_valid ? w_head.ir   : '0;
    assign cmd.cmd_data  = w_valid ? w_head.data : '0;
    assign jdo           = r_jdo;
    assign uir_pulse     = r_uir_pulse;
    assign level         = w_level;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire
